// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path.
//   - RGB 3-3-2 field widths and the packed colour type
//   - background pattern mode encodings
//   - colour-bar palette and the pixel-stage / sprite-axis record types
// No ports: this is a package imported by vga_pixel_gen, vga_sprite_mover
// and later VGA blocks.
package vga_pkg;

    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int RGB_W = R_W + G_W + B_W;
    localparam int CNT_W = 10;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        MODE_BLACK   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SOLID   = 2'd3
    } bg_mode_e;

    localparam rgb_t COLOR_BLACK = 8'h00;
    localparam rgb_t COLOR_WHITE = 8'hFF;

    // Colour bars, left to right.
    localparam rgb_t BAR_0 = 8'hFF;  // white
    localparam rgb_t BAR_1 = 8'hFC;  // yellow
    localparam rgb_t BAR_2 = 8'h1F;  // cyan
    localparam rgb_t BAR_3 = 8'h1C;  // green
    localparam rgb_t BAR_4 = 8'hE3;  // magenta
    localparam rgb_t BAR_5 = 8'hE0;  // red
    localparam rgb_t BAR_6 = 8'h03;  // blue
    localparam rgb_t BAR_7 = 8'h00;  // black

    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_0;
            3'd1:    c = BAR_1;
            3'd2:    c = BAR_2;
            3'd3:    c = BAR_3;
            3'd4:    c = BAR_4;
            3'd5:    c = BAR_5;
            3'd6:    c = BAR_6;
            default: c = BAR_7;
        endcase
        return c;
    endfunction

    // One pixel as it travels through the first pipeline stage.
    typedef struct packed {
        cnt_t h;
        cnt_t v;
        logic color_enable;
        logic h_sync;
        logic v_sync;
        rgb_t solid;
    } pix_stage_t;

    // Blank pixel: colour off, active-low syncs deasserted.
    localparam pix_stage_t PIX_BLANK = '{
        h:            '0,
        v:            '0,
        color_enable: 1'b0,
        h_sync:       1'b1,
        v_sync:       1'b1,
        solid:        '0
    };

    // Position and direction (1 = increasing) of the sprite on one axis.
    typedef struct packed {
        cnt_t pos;
        logic dir;
    } axis_t;

endpackage

// File: rtl/vga_sprite_mover.sv
// Bouncing-box motion.
//   mclk        master clock
//   rst         synchronous active-high reset: box to (0,0), both directions +
//   frame_tick  one-mclk pulse once per frame, during vertical blanking
//   run_q       frame-latched run enable; the box moves only when it is 1
//   box_x/box_y top-left corner of the box
// Each axis steps by STEP per frame and bounces off the screen edges,
// clamping so the box never leaves the visible area.
module vga_sprite_mover
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int BOX_SIZE  = 32,
    parameter int STEP      = 2
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             run_q,
    output logic [CNT_W-1:0] box_x,
    output logic [CNT_W-1:0] box_y
);

    localparam logic [CNT_W:0] STEP_W = (CNT_W+1)'(STEP);
    localparam logic [CNT_W:0] SIZE_W = (CNT_W+1)'(BOX_SIZE);
    localparam logic [CNT_W:0] H_LIM  = (CNT_W+1)'(H_DISPLAY);
    localparam logic [CNT_W:0] V_LIM  = (CNT_W+1)'(V_DISPLAY);

    logic             dir_x;
    logic             dir_y;
    logic [CNT_W-1:0] nx_x;
    logic [CNT_W-1:0] nx_y;
    logic             nx_dx;
    logic             nx_dy;

    // One frame of motion on one axis. Sums are one bit wider than the
    // position so pos+STEP+BOX_SIZE cannot wrap. Landing exactly on the far
    // edge counts as a hit, so the box turns around in the same frame it
    // first touches the edge rather than lingering there for a frame.
    function automatic axis_t step_axis(input logic [CNT_W-1:0] pos,
                                        input logic dir,
                                        input logic [CNT_W:0] limit);
        axis_t          nx;
        logic [CNT_W:0] pos_w;
        logic [CNT_W:0] clamp;
        pos_w  = {1'b0, pos};
        clamp  = limit - SIZE_W;
        nx.pos = pos;
        nx.dir = dir;
        if (dir) begin
            if (pos_w + STEP_W + SIZE_W >= limit) begin
                nx.pos = clamp[CNT_W-1:0];
                nx.dir = 1'b0;
            end else begin
                nx.pos = pos + STEP_W[CNT_W-1:0];
            end
        end else begin
            if (pos_w < STEP_W) begin
                nx.pos = '0;
                nx.dir = 1'b1;
            end else begin
                nx.pos = pos - STEP_W[CNT_W-1:0];
            end
        end
        return nx;
    endfunction

    // Both axes are evaluated together, so a corner hit flips both
    // directions on the same tick.
    always_comb begin
        {nx_x, nx_dx} = step_axis(box_x, dir_x, H_LIM);
        {nx_y, nx_dy} = step_axis(box_y, dir_y, V_LIM);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge mclk) begin
        if (rst) begin
            box_x <= '0;
            box_y <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (frame_tick && run_q) begin
            box_x <= nx_x;
            box_y <= nx_y;
            dir_x <= nx_dx;
            dir_y <= nx_dy;
        end
    end

endmodule

// File: rtl/vga_pixel_gen.sv
// Pattern generator with a bouncing sprite, fed by an external timing
// generator.
//   mclk, rst           master clock; synchronous active-high reset
//   update              pixel-rate square wave; its rising edge is one pixel
//   h_cnt, v_cnt        counts of the pixel being presented
//   color_enable        1 inside the visible area
//   h_sync_in/v_sync_in active-low syncs from the timing generator
//   run                 1 = sprite moves (latched once per frame)
//   mode                background pattern (latched once per frame)
//   solid_rgb           background colour for the solid pattern
//   rgb                 RGB 3-3-2 pixel, two pixels behind the counts
//   h_sync, v_sync      syncs delayed to line up with rgb
//   frame_tick          one-mclk pulse at the start of vertical blanking
module vga_pixel_gen
    import vga_pkg::*;
#(
    parameter int   H_DISPLAY = 640,
    parameter int   V_DISPLAY = 480,
    parameter int   BOX_SIZE  = 32,
    parameter int   STEP      = 2,
    parameter rgb_t BOX_COLOR = 8'hFF
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             update,
    input  logic [CNT_W-1:0] h_cnt,
    input  logic [CNT_W-1:0] v_cnt,
    input  logic             color_enable,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] solid_rgb,
    output logic [RGB_W-1:0] rgb,
    output logic             h_sync,
    output logic             v_sync,
    output logic             frame_tick
);

    localparam int             BAR_W   = H_DISPLAY / 8;
    localparam logic [CNT_W-1:0] V_BLANK = CNT_W'(V_DISPLAY);

    logic             update_q;
    logic             pix_en;
    pix_stage_t       s1;
    bg_mode_e         mode_q;
    logic             run_q;
    logic [CNT_W-1:0] box_x;
    logic [CNT_W-1:0] box_y;
    logic [CNT_W:0]   h_w;
    logic [CNT_W:0]   v_w;
    logic [CNT_W:0]   bx_w;
    logic [CNT_W:0]   by_w;
    logic             box_hit;
    logic [2:0]       bar_idx;
    rgb_t             bg_color;

    // Rising edge of update marks one pixel; everything in the pipeline
    // moves only on that single mclk.
    always_ff @(posedge mclk) begin
        if (rst) update_q <= 1'b0;
        else     update_q <= update;
    end

    assign pix_en = update & ~update_q;

    // Stage 1: capture the pixel and its side information.
    always_ff @(posedge mclk) begin
        if (rst) begin
            s1 <= PIX_BLANK;
        end else if (pix_en) begin
            s1 <= '{
                h:            h_cnt,
                v:            v_cnt,
                color_enable: color_enable,
                h_sync:       h_sync_in,
                v_sync:       v_sync_in,
                solid:        solid_rgb
            };
        end
    end

    // The pixel at (0, V_DISPLAY) opens vertical blanking, which is where the
    // sprite and the frame-latched controls are allowed to change.
    always_ff @(posedge mclk) begin
        if (rst) frame_tick <= 1'b0;
        else     frame_tick <= pix_en && (h_cnt == '0) && (v_cnt == V_BLANK);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            mode_q <= MODE_BLACK;
            run_q  <= 1'b0;
        end else if (frame_tick) begin
            mode_q <= bg_mode_e'(mode);
            run_q  <= run;
        end
    end

    vga_sprite_mover #(
        .H_DISPLAY (H_DISPLAY),
        .V_DISPLAY (V_DISPLAY),
        .BOX_SIZE  (BOX_SIZE),
        .STEP      (STEP)
    ) u_mover (
        .mclk       (mclk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .run_q      (run_q),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    // Hit test in 11 bits so box+BOX_SIZE near the right edge cannot wrap.
    assign h_w  = {1'b0, s1.h};
    assign v_w  = {1'b0, s1.v};
    assign bx_w = {1'b0, box_x};
    assign by_w = {1'b0, box_y};

    assign box_hit = (h_w >= bx_w) && (h_w < bx_w + (CNT_W+1)'(BOX_SIZE)) &&
                     (v_w >= by_w) && (v_w < by_w + (CNT_W+1)'(BOX_SIZE));

    // Bar index from threshold compares; the last threshold passed wins.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_w >= (CNT_W+1)'(k * BAR_W)) bar_idx = 3'(k);
        end
    end

    always_comb begin
        bg_color = COLOR_BLACK;
        case (mode_q)
            MODE_BLACK:   bg_color = COLOR_BLACK;
            MODE_BARS:    bg_color = bar_color(bar_idx);
            MODE_CHECKER: bg_color = (s1.h[5] ^ s1.v[5]) ? COLOR_WHITE : COLOR_BLACK;
            MODE_SOLID:   bg_color = s1.solid;
            default:      bg_color = COLOR_BLACK;
        endcase
    end

    // Stage 2: colour with blanking first, then sprite, then background.
    always_ff @(posedge mclk) begin
        if (rst) begin
            rgb    <= COLOR_BLACK;
            h_sync <= 1'b1;
            v_sync <= 1'b1;
        end else if (pix_en) begin
            if (!s1.color_enable) rgb <= COLOR_BLACK;
            else if (box_hit)     rgb <= BOX_COLOR;
            else                  rgb <= bg_color;
            h_sync <= s1.h_sync;
            v_sync <= s1.v_sync;
        end
    end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen. A second instance with a square screen
// exercises a simultaneous corner bounce on both axes.
module tb_vga_pixel_gen;

    localparam int HD  = 640;
    localparam int VD  = 480;
    localparam int HD2 = 480;
    localparam int BOX = 32;
    localparam int STP = 2;

    logic       mclk = 1'b0;
    logic       rst;
    logic       update;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       color_enable;
    logic       h_sync_in;
    logic       v_sync_in;
    logic       run;
    logic [1:0] mode;
    logic [7:0] solid_rgb;
    logic [7:0] rgb;
    logic       h_sync;
    logic       v_sync;
    logic       frame_tick;
    logic [7:0] rgb2;
    logic       h_sync2;
    logic       v_sync2;
    logic       frame_tick2;

    always #5 mclk = ~mclk;

    vga_pixel_gen dut (
        .mclk(mclk), .rst(rst), .update(update), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .color_enable(color_enable), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .run(run), .mode(mode), .solid_rgb(solid_rgb), .rgb(rgb),
        .h_sync(h_sync), .v_sync(v_sync), .frame_tick(frame_tick)
    );

    vga_pixel_gen #(.H_DISPLAY(HD2)) dut_sq (
        .mclk(mclk), .rst(rst), .update(update), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .color_enable(color_enable), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .run(run), .mode(mode), .solid_rgb(solid_rgb), .rgb(rgb2),
        .h_sync(h_sync2), .v_sync(v_sync2), .frame_tick(frame_tick2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t sb[$];

    logic [7:0] bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

    // Reference state: sprite for both instances and frame-latched controls.
    int         m_x, m_y, m2_x, m2_y, moves;
    bit         m_dx, m_dy, m2_dx, m2_dy;
    bit         m_run_q;
    logic [1:0] m_mode_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_axis(inout int p, inout bit d, input int lim);
        if (d) begin
            if (p + STP + BOX >= lim) begin
                p = lim - BOX;
                d = 1'b0;
            end else begin
                p = p + STP;
            end
        end else begin
            if (p < STP) begin
                p = 0;
                d = 1'b1;
            end else begin
                p = p - STP;
            end
        end
    endfunction

    function automatic void model_reset();
        m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
        m2_x = 0; m2_y = 0; m2_dx = 1; m2_dy = 1;
        m_run_q = 0; m_mode_q = 2'd0; moves = 0;
    endfunction

    function automatic void model_tick();
        if (m_run_q) begin
            model_axis(m_x, m_dx, HD);
            model_axis(m_y, m_dy, VD);
            model_axis(m2_x, m2_dx, HD2);
            model_axis(m2_y, m2_dy, VD);
            moves++;
        end
        m_run_q  = run;
        m_mode_q = mode;
    endfunction

    function automatic logic [7:0] exp_color(input int h, input int v, input bit ce,
                                             input logic [7:0] sol);
        if (!ce) return 8'h00;
        if (h >= m_x && h < m_x + BOX && v >= m_y && v < m_y + BOX) return 8'hFF;
        case (m_mode_q)
            2'd0:    return 8'h00;
            2'd1:    return bars[h / (HD / 8)];
            2'd2:    return ((((h / 32) + (v / 32)) % 2) == 1) ? 8'hFF : 8'h00;
            default: return sol;
        endcase
    endfunction

    // One pixel: rising update (the pix_en edge), then a hold edge. The
    // output compared at the end belongs to the pixel driven one step back.
    task automatic pix(input int h, input int v, input bit ce, input bit hs, input bit vs,
                       input logic [7:0] sol);
        exp_t e;
        bit   is_tick;
        is_tick = (h == 0 && v == VD);
        @(negedge mclk);
        h_cnt = 10'(h); v_cnt = 10'(v); color_enable = ce;
        h_sync_in = hs; v_sync_in = vs; solid_rgb = sol; update = 1'b1;
        e.rgb = exp_color(h, v, ce, sol); e.hs = hs; e.vs = vs;
        sb.push_back(e);
        @(posedge mclk); #1;
        check("frame_tick", frame_tick, is_tick);
        check("frame_tick_sq", frame_tick2, is_tick);
        @(negedge mclk);
        update = 1'b0;
        @(posedge mclk); #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            check("rgb", rgb, e.rgb);
            check("h_sync", h_sync, e.hs);
            check("v_sync", v_sync, e.vs);
        end
        if (is_tick) begin
            model_tick();
            check("box_x", dut.box_x, m_x);
            check("box_y", dut.box_y, m_y);
            check("sq_box_x", dut_sq.box_x, m2_x);
            check("sq_box_y", dut_sq.box_y, m2_y);
        end
    endtask

    task automatic tick();
        pix(0, VD, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    // Reset for one mclk; the pipeline then holds a blank pixel.
    task automatic do_reset();
        exp_t e;
        @(negedge mclk);
        rst = 1'b1; update = 1'b0;
        @(posedge mclk);
        @(negedge mclk);
        rst = 1'b0;
        model_reset();
        sb.delete();
        e.rgb = 8'h00; e.hs = 1'b1; e.vs = 1'b1;
        sb.push_back(e);
        check("rst_rgb", rgb, 8'h00);
        check("rst_h_sync", h_sync, 1'b1);
        check("rst_v_sync", v_sync, 1'b1);
        check("rst_frame_tick", frame_tick, 1'b0);
        check("rst_box_x", dut.box_x, 0);
        check("rst_box_y", dut.box_y, 0);
        check("rst_dir_x", dut.u_mover.dir_x, 1'b1);
        check("rst_dir_y", dut.u_mover.dir_y, 1'b1);
        check("rst_mode_q", dut.mode_q, 2'd0);
        check("rst_run_q", dut.run_q, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; update = 1'b0; h_cnt = '0; v_cnt = '0; color_enable = 1'b0;
        h_sync_in = 1'b1; v_sync_in = 1'b1; run = 1'b0; mode = 2'd0; solid_rgb = 8'h00;
        repeat (2) @(posedge mclk);
        do_reset();

        // Latch bars, sprite frozen; then the two-pixel latency and syncs.
        mode = 2'd1; run = 1'b0;
        tick();
        pix(0, 0, 1'b1, 1'b0, 1'b0, 8'h00);
        pix(1, 0, 1'b1, 1'b1, 1'b1, 8'h00);
        check("latency_rgb_after_2", rgb, 8'hFF);
        check("latency_hs_after_2", h_sync, 1'b0);
        check("latency_vs_after_2", v_sync, 1'b0);

        // All eight bars including their edges, and a blanked pixel.
        pix(79, 100, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(80, 100, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(170, 100, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(250, 100, 1'b1, 1'b0, 1'b1, 8'h00);
        pix(330, 100, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(410, 100, 1'b1, 1'b1, 1'b0, 8'h00);
        pix(490, 100, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(639, 100, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(100, 100, 1'b0, 1'b1, 1'b1, 8'h00);

        // The first tick with run=1 only latches it; 20 moving frames follow.
        mode = 2'd0; run = 1'b1;
        tick();
        repeat (20) tick();
        check("req036_box_x", dut.box_x, 40);
        check("req036_box_y", dut.box_y, 40);
        check("req036_dir_x", dut.u_mover.dir_x, 1'b1);
        check("req036_dir_y", dut.u_mover.dir_y, 1'b1);
        pix(40, 40, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(72, 40, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(71, 71, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(39, 40, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(40, 72, 1'b1, 1'b1, 1'b1, 8'h00);
        check("req036_bg_at_40_72", rgb, 8'h00);

        // Run on to the right edge; the square instance hits its corner first.
        while (moves < 303) begin
            tick();
            if (moves == 224) begin
                check("corner_sq_x", dut_sq.box_x, 448);
                check("corner_sq_y", dut_sq.box_y, 448);
                check("corner_sq_dir_x", dut_sq.u_mover.dir_x, 1'b0);
                check("corner_sq_dir_y", dut_sq.u_mover.dir_y, 1'b0);
            end
        end
        check("edge_x_606", dut.box_x, 606);
        check("edge_dir_606", dut.u_mover.dir_x, 1'b1);
        tick();
        check("edge_x_608", dut.box_x, 608);
        check("edge_dir_608", dut.u_mover.dir_x, 1'b0);
        tick();
        check("edge_x_back", dut.box_x, 606);

        // Checkerboard frame; a mid-frame switch to solid waits for the tick.
        mode = 2'd2;
        tick();
        mode = 2'd3;
        pix(40, 40, 1'b1, 1'b1, 1'b1, 8'h1C);
        pix(40, 10, 1'b1, 1'b1, 1'b1, 8'h1C);
        pix(10, 40, 1'b1, 1'b1, 1'b1, 8'h1C);
        pix(100, 100, 1'b1, 1'b1, 1'b1, 8'h1C);
        pix(650, 100, 1'b0, 1'b0, 1'b1, 8'h1C);
        tick();
        pix(40, 40, 1'b1, 1'b1, 1'b1, 8'h1C);
        pix(10, 10, 1'b1, 1'b1, 1'b1, 8'h1C);
        pix(50, 50, 1'b1, 1'b1, 1'b1, 8'h55);
        pix(100, 490, 1'b0, 1'b1, 1'b0, 8'h1C);
        pix(610, 290, 1'b1, 1'b1, 1'b1, 8'h1C);
        pix(600, 290, 1'b1, 1'b1, 1'b1, 8'h1C);
        pix(601, 290, 1'b1, 1'b1, 1'b1, 8'h1C);
        check("solid_next_frame", rgb, 8'h1C);

        // Reset mid-frame with live pixels in the pipeline.
        pix(300, 200, 1'b1, 1'b0, 1'b1, 8'h1C);
        pix(300, 200, 1'b1, 1'b0, 1'b1, 8'h1C);
        do_reset();
        pix(301, 200, 1'b1, 1'b1, 1'b1, 8'h1C);
        pix(0, 479, 1'b0, 1'b1, 1'b1, 8'h00);
        pix(1, 480, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        pix(5, 5, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(40, 5, 1'b1, 1'b1, 1'b1, 8'h00);
        pix(0, 0, 1'b0, 1'b1, 1'b1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
